// File: rtl/rx_packet_gen_if.sv
// AXI-stream bundle driven by the receive-side packet generator.
// The master drives the beat and the slave returns tready.
interface rx_packet_gen_if #(
   parameter int DW = 512
);
   logic [DW-1:0]   tdata;
   logic [DW/8-1:0] tkeep;
   logic            tlast;
   logic            tuser;
   logic            tvalid;
   logic            tready;

   modport master (
      output tdata,
      output tkeep,
      output tlast,
      output tuser,
      output tvalid,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tkeep,
      input  tlast,
      input  tuser,
      input  tvalid,
      output tready
   );
endinterface

// File: rtl/rx_packet_gen.sv
// AXI-stream test packet generator: bursts of FD/MD/FC/custom-length packets
// with a {packet, beat} data pattern and optional bad marking on TUSER.
module rx_packet_gen #(
   parameter int DW = 512
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic                  stop,
   input  logic [1:0]            cfg_type,
   input  logic [15:0]           cfg_length,
   input  logic [31:0]           cfg_count,
   input  logic [7:0]            cfg_gap,
   input  logic                  cfg_bad,
   output logic                  busy,
   output logic [31:0]           packets_sent,
   rx_packet_gen_if.master       axis
);

   localparam int BPB = DW / 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   function automatic logic [15:0] pkt_len(input logic [1:0] ptype,
                                           input logic [15:0] len);
      logic [15:0] res;
      case (ptype)
         2'd0:    res = 16'd4160;
         2'd1:    res = 16'd192;
         2'd2:    res = 16'd68;
         default: res = (len == 16'd0) ? 16'd1 : len;
      endcase
      return res;
   endfunction

   // Ceiling division carried in 17 bits so lengths near 64 KiB do not wrap.
   function automatic logic [15:0] beat_count(input logic [15:0] len);
      logic [16:0] sum;
      sum = {1'b0, len} + 17'(BPB - 1);
      return 16'(sum / 17'(BPB));
   endfunction

   function automatic logic [BPB-1:0] last_keep(input logic [15:0] len);
      int rem;
      rem = int'(len % 16'(BPB));
      if (rem == 0)
         return {BPB{1'b1}};
      return {BPB{1'b1}} >> (BPB - rem);
   endfunction

   state_t          state;
   state_t          state_nxt;
   logic            stop_pend;
   logic [15:0]     beat_idx;
   logic [15:0]     pkt_seq;
   logic [7:0]      gap_cnt;

   logic [15:0]     nbeats_q;
   logic [BPB-1:0]  lkeep_q;
   logic [31:0]     count_q;
   logic [7:0]      gap_q;
   logic            bad_q;

   logic            send_vld;
   logic            start_acc;
   logic            hs;
   logic            last_beat;
   logic            stop_any;
   logic            burst_done;

   assign send_vld   = (state == S_SEND);
   assign start_acc  = start && (state == S_IDLE);
   assign hs         = send_vld && axis.tready;
   assign last_beat  = (beat_idx == nbeats_q - 16'd1);
   assign stop_any   = stop_pend || stop;
   assign burst_done = ((count_q != 32'd0) && (packets_sent + 32'd1 == count_q)) || stop_any;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start)
               state_nxt = S_SEND;
         end
         S_SEND: begin
            if (hs && last_beat) begin
               if (burst_done)
                  state_nxt = S_IDLE;
               else if (gap_q != 8'd0)
                  state_nxt = S_GAP;
               else
                  state_nxt = S_SEND;
            end
         end
         S_GAP: begin
            if (stop_any)
               state_nxt = S_IDLE;
            else if (gap_cnt == 8'd0)
               state_nxt = S_SEND;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= S_IDLE;
         stop_pend    <= 1'b0;
         packets_sent <= 32'd0;
         pkt_seq      <= 16'd0;
         beat_idx     <= 16'd0;
         gap_cnt      <= 8'd0;
      end else begin
         state <= state_nxt;

         // A stop only matters while a burst is running and dies with it.
         if ((state == S_IDLE) || (state_nxt == S_IDLE))
            stop_pend <= 1'b0;
         else if (stop)
            stop_pend <= 1'b1;

         if (start_acc) begin
            packets_sent <= 32'd0;
            pkt_seq      <= 16'd0;
            beat_idx     <= 16'd0;
         end else if (hs) begin
            if (last_beat) begin
               beat_idx     <= 16'd0;
               pkt_seq      <= pkt_seq + 16'd1;
               packets_sent <= packets_sent + 32'd1;
            end else begin
               beat_idx <= beat_idx + 16'd1;
            end
         end

         // Preloaded to gap-1 so GAP lasts exactly cfg_gap cycles.
         if (state == S_SEND)
            gap_cnt <= gap_q - 8'd1;
         else if (state == S_GAP)
            gap_cnt <= gap_cnt - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (start_acc) begin
         nbeats_q <= beat_count(pkt_len(cfg_type, cfg_length));
         lkeep_q  <= last_keep(pkt_len(cfg_type, cfg_length));
         count_q  <= cfg_count;
         gap_q    <= cfg_gap;
         bad_q    <= cfg_bad;
      end
   end

   assign busy        = (state != S_IDLE);
   assign axis.tvalid = send_vld;
   assign axis.tdata  = send_vld ? {(DW/32){pkt_seq, beat_idx}} : '0;
   assign axis.tkeep  = send_vld ? (last_beat ? lkeep_q : {BPB{1'b1}}) : '0;
   assign axis.tlast  = send_vld && last_beat;
   assign axis.tuser  = send_vld && last_beat && bad_q;

endmodule

// File: tb/tb_rx_packet_gen.sv
// Bench for rx_packet_gen: table of burst configurations plus random bursts,
// each beat checked against a packet-level reference model.
module tb_rx_packet_gen;

   localparam int DW  = 512;
   localparam int BPB = DW / 8;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [1:0]  cfg_type = '0;
   logic [15:0] cfg_length = '0;
   logic [31:0] cfg_count = '0;
   logic [7:0]  cfg_gap = '0;
   logic        cfg_bad = 1'b0;
   logic        busy;
   logic [31:0] packets_sent;

   int n_checks = 0;
   int n_fail   = 0;

   rx_packet_gen_if #(.DW(DW)) axis ();

   rx_packet_gen #(.DW(DW)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start),
      .stop         (stop),
      .cfg_type     (cfg_type),
      .cfg_length   (cfg_length),
      .cfg_count    (cfg_count),
      .cfg_gap      (cfg_gap),
      .cfg_bad      (cfg_bad),
      .busy         (busy),
      .packets_sent (packets_sent),
      .axis         (axis)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  ctype;
      logic [15:0] clen;
      logic [31:0] ccnt;
      logic [7:0]  cgap;
      logic        cbad;
      int          rdy_pct;
      int          stop_at;
      bit          start_busy;
      bit          start_last;
      int          exp_pkts;
      int          exp_beats;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] t, input logic [15:0] len, input logic [31:0] cnt,
                               input logic [7:0] gap, input logic bad, input int rdy, input int stop_at,
                               input bit sb, input bit sl, input int ep, input int eb);
      vec_t v;
      v.ctype = t; v.clen = len; v.ccnt = cnt; v.cgap = gap; v.cbad = bad;
      v.rdy_pct = rdy; v.stop_at = stop_at; v.start_busy = sb; v.start_last = sl;
      v.exp_pkts = ep; v.exp_beats = eb;
      return v;
   endfunction

   task automatic run_test(input vec_t v);
      int L, B, rem;
      logic [63:0]  lkeep, exp_keep;
      logic [511:0] exp_data, prev_data;
      logic [66:0]  prev_meta;
      int pkt, beat, pkts_done, beats_done, stop_pkt, gap_run, cycles;
      bit done, stalled, gap_pending, is_last;

      case (v.ctype)
         2'd0:    L = 4160;
         2'd1:    L = 192;
         2'd2:    L = 68;
         default: L = (v.clen == 16'd0) ? 1 : int'(v.clen);
      endcase
      B     = (L + BPB - 1) / BPB;
      rem   = L % BPB;
      lkeep = (rem == 0) ? {64{1'b1}} : ((64'd1 << rem) - 64'd1);

      @(posedge clk); #1;
      cfg_type = v.ctype; cfg_length = v.clen; cfg_count = v.ccnt;
      cfg_gap = v.cgap; cfg_bad = v.cbad; start = 1'b1; stop = 1'b0; axis.tready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("first_beat_latency", {busy, axis.tvalid}, 2'b11);

      pkt = 0; beat = 0; pkts_done = 0; beats_done = 0; stop_pkt = -1;
      gap_run = 0; cycles = 0; done = 0; stalled = 0; gap_pending = 0;
      while (!done && cycles < 20000) begin
         start = 1'b0;
         stop  = 1'b0;
         axis.tready = ($urandom_range(99) < v.rdy_pct);
         if (v.stop_at >= 0 && stop_pkt < 0 && beats_done >= v.stop_at && axis.tvalid) begin
            stop = 1'b1;
            stop_pkt = pkt;
         end
         if (v.start_busy && beats_done == 20) begin
            start = 1'b1; cfg_type = 2'd2; cfg_count = 32'd1; cfg_gap = 8'd0;
         end
         if (v.start_last && axis.tvalid && axis.tlast && axis.tready && (pkts_done + 1 == int'(v.ccnt)))
            start = 1'b1;

         @(negedge clk);
         if (stalled) begin
            chk("stall_hold_data", axis.tdata, prev_data);
            chk("stall_hold_meta", {axis.tvalid, axis.tkeep, axis.tlast, axis.tuser}, prev_meta);
         end
         if (axis.tvalid) begin
            if (gap_pending) begin
               chk("gap_cycles", gap_run, v.cgap);
               gap_pending = 0;
            end
            if (axis.tready) begin
               is_last = (beat == B - 1);
               for (int w = 0; w < DW / 32; w++)
                  exp_data[w*32 +: 32] = {pkt[15:0], beat[15:0]};
               exp_keep = is_last ? lkeep : {64{1'b1}};
               chk("beat_data", axis.tdata, exp_data);
               chk("beat_meta", {axis.tkeep, axis.tlast, axis.tuser}, {exp_keep, is_last, is_last & v.cbad});
               beats_done++;
               stalled = 0;
               if (is_last) begin
                  beat = 0; pkt++; pkts_done++;
                  if ((v.ccnt != 0 && pkts_done == int'(v.ccnt)) || (stop_pkt >= 0 && pkts_done == stop_pkt + 1))
                     done = 1;
                  else begin
                     gap_pending = 1;
                     gap_run = 0;
                  end
               end else begin
                  beat++;
               end
            end else begin
               stalled   = 1;
               prev_data = axis.tdata;
               prev_meta = {1'b1, axis.tkeep, axis.tlast, axis.tuser};
            end
         end else begin
            gap_run++;
            stalled = 0;
         end
         @(posedge clk); #1;
         cycles++;
      end
      start = 1'b0; stop = 1'b0;
      if (!done)
         chk("burst_timeout", 1'b0, 1'b1);
      chk("idle_after_burst", {busy, axis.tvalid}, 2'b00);
      chk("packets_sent", packets_sent, pkts_done);
      if (v.exp_pkts >= 0)
         chk("burst_packets", pkts_done, v.exp_pkts);
      if (v.exp_beats >= 0)
         chk("burst_beats", beats_done, v.exp_beats);
      axis.tready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation time exceeded");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t rv;
      axis.tready = 1'b0;

      #12;
      chk("reset_outputs", {busy, packets_sent, axis.tvalid, axis.tlast, axis.tuser}, '0);
      chk("reset_tdata", axis.tdata, '0);
      chk("reset_tkeep", axis.tkeep, '0);
      @(posedge clk); #1;
      resetn = 1'b1;

      //            type  len      cnt    gap bad rdy stop sb sl pkts beats
      vecs.push_back(mk(2'd2, 16'd0,     32'd3, 8'd0, 1'b0, 100, -1, 0, 0, 3, 6));
      vecs.push_back(mk(2'd0, 16'd0,     32'd1, 8'd0, 1'b0, 100, -1, 0, 0, 1, 65));
      vecs.push_back(mk(2'd1, 16'd0,     32'd2, 8'd5, 1'b1, 100, -1, 0, 0, 2, 6));
      vecs.push_back(mk(2'd3, 16'd100,   32'd4, 8'd0, 1'b0, 50,  -1, 0, 0, 4, 8));
      vecs.push_back(mk(2'd3, 16'd0,     32'd2, 8'd1, 1'b1, 100, -1, 0, 0, 2, 2));
      vecs.push_back(mk(2'd3, 16'd64,    32'd3, 8'd2, 1'b0, 100, -1, 0, 1, 3, 3));
      vecs.push_back(mk(2'd3, 16'd65535, 32'd1, 8'd0, 1'b1, 80,  -1, 0, 0, 1, 1024));
      vecs.push_back(mk(2'd0, 16'd0,     32'd0, 8'd0, 1'b0, 100, 10, 1, 0, 1, 65));
      vecs.push_back(mk(2'd1, 16'd0,     32'd2, 8'd3, 1'b0, 60,  -1, 0, 1, 2, 6));
      foreach (vecs[i])
         run_test(vecs[i]);

      repeat (3) @(posedge clk);
      #1;
      chk("packets_sent_retained", packets_sent, 32'd2);

      // Stop while idle must not cut the following burst short.
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      run_test(mk(2'd2, 16'd0, 32'd2, 8'd0, 1'b0, 100, -1, 0, 0, 2, 4));

      // Reset in the middle of an MD packet.
      cfg_type = 2'd1; cfg_count = 32'd0; cfg_gap = 8'd0; cfg_bad = 1'b0;
      start = 1'b1; axis.tready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("md_beat1_before_reset", {axis.tvalid, axis.tdata[31:0]}, {1'b1, 32'h0000_0001});
      resetn = 1'b0;
      #1;
      chk("reset_async_drop", {axis.tvalid, axis.tlast, busy}, 3'b000);
      @(posedge clk); #1;
      resetn = 1'b1;
      axis.tready = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_state", {busy, packets_sent, axis.tvalid}, '0);
      run_test(mk(2'd2, 16'd0, 32'd1, 8'd0, 1'b1, 100, -1, 0, 0, 1, 2));

      for (int r = 0; r < 6; r++) begin
         rv = mk(2'($urandom_range(3)), 16'($urandom_range(300)), 32'($urandom_range(3, 1)),
                 8'($urandom_range(3)), 1'($urandom_range(1)), int'($urandom_range(100, 30)),
                 -1, 0, 0, -1, -1);
         rv.exp_pkts = int'(rv.ccnt);
         run_test(rv);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rx_packet_gen.md
Name: rx_packet_gen

Overview:
AXI-stream packet generator that drives the stream monitored by the receive-side packet counter.
It emits bursts of test packets of the three canonical sizes (FD 4160 B, MD 192 B, FC 68 B) or a custom size, with optional bad-packet marking on TUSER.
It is used on the bench and in loopback builds to exercise the counter's FD/MD/FC/other/bad classification.

Parameters:
DW, 512, data width in bits; bytes-per-beat BPB = DW/8; DW is a multiple of 32.

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; latches all cfg_* and begins a burst; ignored while busy=1
stop  input  1  pulse; finish the current packet, then go idle
cfg_type  input  2  0=FD (4160 B), 1=MD (192 B), 2=FC (68 B), 3=custom (cfg_length)
cfg_length  input  16  custom packet length in bytes; 0 is treated as 1
cfg_count  input  32  packets in the burst; 0 = run until stop
cfg_gap  input  8  idle cycles (tvalid=0) between packets
cfg_bad  input  1  1 = assert tuser on the last beat of every packet
busy  output  1  high from the cycle after an accepted start until the burst ends
packets_sent  output  32  packets completed since the last accepted start
axis_tdata  output  DW  stream data
axis_tkeep  output  DW/8  byte enables
axis_tlast  output  1  last beat of packet
axis_tuser  output  1  bad-packet flag; valid only with tlast
axis_tvalid  output  1  stream valid
axis_tready  input  1  stream ready

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, packets_sent, axis_tvalid, axis_tlast, axis_tuser, axis_tdata, axis_tkeep all 0. A reset mid-packet drops tvalid immediately; no tlast is emitted.
- Packet length L: FD=4160, MD=192, FC=68, custom=max(cfg_length,1).
- Beat count B = ceil(L/BPB), 16-bit arithmetic.
- Every beat except the last has tkeep all ones. The last beat has the low (L mod BPB) bits set, or all ones if the remainder is 0. tkeep is always contiguous from bit 0.
- tdata: every 32-bit word = {pkt_seq[15:0], beat_idx[15:0]}.
  - pkt_seq resets to 0 on start and increments per completed packet, wrapping at 16 bits.
  - beat_idx starts at 0 for each packet.
- tuser = cfg_bad on the last beat only; 0 on all other beats.
- States:
  - IDLE: on start go to SEND; tvalid=1 in the next cycle (start at cycle N -> first beat presented at N+1); busy=1 from N+1.
  - SEND: beat advances only on tvalid&tready. On handshake of the last beat, packets_sent increments. Then:
    - if cfg_count≠0 and packets_sent+1==cfg_count, or a stop is pending -> IDLE;
    - else if cfg_gap≠0 -> GAP;
    - else the next packet's beat 0 is presented in the very next cycle.
  - GAP: tvalid=0 for exactly cfg_gap cycles, then SEND. A pending stop in GAP -> IDLE at the next cycle.
  - Leaving for IDLE clears busy and tvalid in the same cycle.
- AXI rules: while tvalid=1 and tready=0, tdata, tkeep, tlast and tuser hold stable; tvalid never drops without a handshake (stop does not abort a beat).
- stop is latched as pending; it is cleared on entry to IDLE. A stop while IDLE has no effect.
- A start that coincides with the final handshake of a burst is ignored (busy is still 1).
- packets_sent wraps at 2^32; it is cleared on an accepted start and retained when idle.

Test Plan:
- DW=512, cfg_type=2, cfg_count=3, cfg_gap=0, tready=1 -> 6 beats; each packet is 2 beats; last beat tkeep=0x...000F with tlast=1; packets_sent=3; busy falls after the 6th beat.
- cfg_type=0, cfg_count=1 -> 65 beats, all tkeep full, tlast on beat 64, last-beat tdata words=0x00000040; downstream counter fd_packets=1.
- cfg_type=1, cfg_bad=1, cfg_count=2, cfg_gap=5 -> 3-beat packets; tuser=1 only on the last beats; exactly 5 tvalid-low cycles between packets; counter bad_packets=2.
- Random tready (50%), cfg_type=3, cfg_length=100, cfg_count=4 -> every packet is 2 beats with last tkeep=36 ones; no data change while stalled; packets_sent=4.
- cfg_count=0, stop pulsed during beat 10 of an FD packet -> the packet completes through beat 64, then IDLE; a start issued while busy is ignored.
- resetn low during beat 1 of an MD packet -> tvalid=0 asynchronously; after release, busy=0 and packets_sent=0; a new start behaves normally.
